// File: rtl/sl_wb_reg_slave.sv
// sl_wb_reg_slave: Wishbone classic single-access register slave.
//
// A bank of NUM_REGS 32-bit registers. Register 0 is a read-only ID word
// (ID_VALUE); registers 1..NUM_REGS-1 are read/write with byte enables.
// Every access is answered after WAIT_CYCLES wait states with a one-cycle
// ACK pulse, or with an ERR pulse when the word index is not mapped.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   wb_cyc_i  in   bus cycle in progress
//   wb_stb_i  in   strobe; an access needs cyc & stb
//   wb_we_i   in   1 = write, 0 = read
//   wb_adr_i  in   byte address; word index = wb_adr_i[9:2]
//   wb_sel_i  in   write byte enables
//   wb_dat_i  in   write data
//   wb_dat_o  out  read data, non-zero only alongside wb_ack_o
//   wb_ack_o  out  normal termination pulse
//   wb_err_o  out  error termination pulse (unmapped index)

module sl_wb_reg_slave #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'h5E1E_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    // Counter holds at most WAIT_CYCLES-1, so it never wraps.
    localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic        req;
    logic [7:0]  idx;
    logic        hit;
    logic        go_resp;
    logic        wr_en;
    logic [31:0] rd_data;

    logic        ack_d, err_d;
    logic [31:0] dat_d;

    logic [31:0] regs_q [1:NUM_REGS-1];

    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[31:10], wb_adr_i[1:0]};

    assign req = wb_cyc_i & wb_stb_i;
    assign idx = wb_adr_i[9:2];
    assign hit = ({1'b0, idx} < 9'(NUM_REGS));

    // Next-state logic. go_resp marks the edge that enters RESP: decode and
    // commit happen there, and only if the request is still present.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                        go_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntW'(WAIT_CYCLES - 1);
                    end
                end
            end
            StWait: begin
                if (!req) begin
                    // Master withdrew: abort silently.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = StResp;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Read mux; index 0 and unmatched indices fall back to the ID word,
    // unmapped reads are masked to zero below.
    always_comb begin
        rd_data = ID_VALUE;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (idx == 8'(i)) begin
                rd_data = regs_q[i];
            end
        end
    end

    assign wr_en = go_resp & hit & wb_we_i;

    always_comb begin
        ack_d = go_resp & hit;
        err_d = go_resp & ~hit;
        dat_d = (go_resp & hit & ~wb_we_i) ? rd_data : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wb_ack_o <= ack_d;
            wb_err_o <= err_d;
            wb_dat_o <= dat_d;
        end
    end

    // Index 0 has no storage, so writes to it drop out naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (wr_en) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (idx == 8'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wb_sel_i[b]) begin
                            regs_q[i][8*b +: 8] <= wb_dat_i[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sl_wb_reg_slave.sv
module tb_sl_wb_reg_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc0, cyc3, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [31:0] dat0, dat3;
    logic        ack0, err0, ack3, err3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sl_wb_reg_slave #(.NUM_REGS(8), .WAIT_CYCLES(0), .ID_VALUE(32'h5E1E_0001)) u_w0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_cyc_i (cyc0),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_sel_i (sel),
        .wb_dat_i (wdat),
        .wb_dat_o (dat0),
        .wb_ack_o (ack0),
        .wb_err_o (err0)
    );

    sl_wb_reg_slave #(.NUM_REGS(8), .WAIT_CYCLES(3), .ID_VALUE(32'h5E1E_0001)) u_w3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_cyc_i (cyc3),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_sel_i (sel),
        .wb_dat_i (wdat),
        .wb_dat_o (dat3),
        .wb_ack_o (ack3),
        .wb_err_o (err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start(input bit w3, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cyc0 = !w3;
        cyc3 = w3;
        stb  = 1'b1;
        we   = w;
        adr  = a;
        wdat = d;
        sel  = s;
    endtask

    task automatic stop();
        @(negedge clk);
        cyc0 = 1'b0;
        cyc3 = 1'b0;
        stb  = 1'b0;
    endtask

    // Full access: w3 selects the 3-wait-state instance (ack after 4 edges),
    // otherwise the zero-wait instance (ack after 1 edge).
    task automatic access(input bit w3, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic ack, output logic err, output logic [31:0] rd);
        int lat;
        lat = w3 ? 4 : 1;
        start(w3, w, a, d, s);
        for (int i = 1; i < lat; i++) begin
            @(posedge clk);
            #1;
            chk("no_early_resp", {30'b0, ack3, err3}, 32'h0);
        end
        @(posedge clk);
        #1;
        ack = w3 ? ack3 : ack0;
        err = w3 ? err3 : err0;
        rd  = w3 ? dat3 : dat0;
        stop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        a, e;
        logic [31:0] r;
        logic [3:0]  pat;

        rst_n = 1'b0;
        cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 32'h0; wdat = 32'h0; sel = 4'h0;
        #1;
        chk("reset_outs_w0", {dat0 | dat3}, 32'h0);
        chk("reset_flags", {28'b0, ack0, err0, ack3, err3}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ID register and a fresh register
        access(0, 1'b0, 32'h0, 32'h0, 4'h0, a, e, r);
        chk("rd_id_ack", {31'b0, a}, 32'h1);
        chk("rd_id_err", {31'b0, e}, 32'h0);
        chk("rd_id_dat", r, 32'h5E1E_0001);
        access(0, 1'b0, 32'h4, 32'h0, 4'h0, a, e, r);
        chk("rd4_ack", {31'b0, a}, 32'h1);
        chk("rd4_dat", r, 32'h0);

        // Full and partial writes
        access(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, a, e, r);
        chk("wr8_ack", {31'b0, a}, 32'h1);
        chk("wr8_dat_zero", r, 32'h0);
        access(0, 1'b0, 32'h8, 32'h0, 4'h0, a, e, r);
        chk("rd8_full", r, 32'hDEAD_BEEF);
        access(0, 1'b1, 32'h8, 32'h0000_0011, 4'h1, a, e, r);
        access(0, 1'b0, 32'h8, 32'h0, 4'h0, a, e, r);
        chk("rd8_byte0", r, 32'hDEAD_BE11);
        access(0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0, a, e, r);
        chk("wr8_sel0_ack", {31'b0, a}, 32'h1);
        access(0, 1'b0, 32'hB, 32'h0, 4'h0, a, e, r);
        chk("rd8_sel0_lowbits", r, 32'hDEAD_BE11);

        // Register 0 is read-only but acks writes
        access(0, 1'b1, 32'h0, 32'h1234_5678, 4'hF, a, e, r);
        chk("wr0_ack", {31'b0, a}, 32'h1);
        access(0, 1'b0, 32'h400, 32'h0, 4'h0, a, e, r);
        chk("rd0_after_wr", r, 32'h5E1E_0001);

        // Unmapped index
        access(0, 1'b0, 32'h20, 32'h0, 4'h0, a, e, r);
        chk("rd20_flags", {30'b0, a, e}, 32'h1);
        chk("rd20_dat", r, 32'h0);
        access(0, 1'b1, 32'h20, 32'hAAAA_AAAA, 4'hF, a, e, r);
        chk("wr20_flags", {30'b0, a, e}, 32'h1);
        for (int i = 1; i < 8; i++) begin
            access(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, a, e, r);
            chk("regs_unchanged", r, (i == 2) ? 32'hDEAD_BE11 : 32'h0);
        end

        // Back-to-back: one access per two cycles
        start(0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            pat[i] = ack0;
        end
        stop();
        chk("b2b_ack_pattern", {28'b0, pat}, 32'h5);

        // Wait states: ack exactly on the 4th edge
        access(1, 1'b1, 32'h4, 32'hCAFE_F00D, 4'hF, a, e, r);
        chk("w3_wr_ack", {31'b0, a}, 32'h1);
        @(posedge clk);
        #1;
        chk("w3_ack_pulse", {31'b0, ack3}, 32'h0);
        access(1, 1'b0, 32'h4, 32'h0, 4'h0, a, e, r);
        chk("w3_rd_ack", {31'b0, a}, 32'h1);
        chk("w3_rd_dat", r, 32'hCAFE_F00D);

        // Abort by dropping stb during WAIT
        start(1, 1'b1, 32'h8, 32'h1111_1111, 4'hF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        stb = 1'b0;
        pat = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            pat[i] = ack3 | err3;
        end
        chk("abort_no_resp", {28'b0, pat}, 32'h0);
        stop();
        access(1, 1'b0, 32'h8, 32'h0, 4'h0, a, e, r);
        chk("abort_next_ack", {31'b0, a}, 32'h1);
        chk("abort_no_write", r, 32'h0);

        // Asynchronous reset clears a live response immediately
        start(0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        chk("pre_reset_ack", {31'b0, ack0}, 32'h1);
        #1;
        rst_n = 1'b0;
        cyc0 = 1'b0;
        stb = 1'b0;
        #1;
        chk("async_reset_ack", {31'b0, ack0}, 32'h0);
        chk("async_reset_dat", dat0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during WAIT of a write
        start(1, 1'b1, 32'h4, 32'h5555_5555, 4'hF);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        cyc3 = 1'b0;
        stb = 1'b0;
        #1;
        chk("wait_reset_outs", {28'b0, ack3, err3, 2'b0} | dat3, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        access(1, 1'b0, 32'h4, 32'h0, 4'h0, a, e, r);
        chk("post_reset_rd4_ack", {31'b0, a}, 32'h1);
        chk("post_reset_rd4", r, 32'h0);
        access(0, 1'b0, 32'h8, 32'h0, 4'h0, a, e, r);
        chk("post_reset_rd8", r, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sl_wb_reg_slave.md
Name: sl_wb_reg_slave

Overview:
- Wishbone classic single-access slave: a bank of NUM_REGS 32-bit registers with programmable wait states and an error response for unmapped addresses.
- Terminates the cycles that master-side agents drive on a wb_if, and is the DUT-side responder for bus monitors on that interface.
- Serves as a register target in Selen subsystem benches and as a template for peripheral register blocks.

Parameters:
- NUM_REGS, 8: number of 32-bit registers; legal range 2..256.
- WAIT_CYCLES, 0: wait states inserted between request sampling and the ACK/ERR cycle; legal range 0..15.
- ID_VALUE, 32'h5E1E_0001: constant returned by register 0, which is read-only.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_cyc_i  in  1  bus cycle in progress.
- wb_stb_i  in  1  strobe; a valid access requires wb_cyc_i & wb_stb_i.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  32  byte address; word index = wb_adr_i[9:2]; bits [1:0] are ignored.
- wb_sel_i  in  4  byte enables for writes; bit n enables byte n.
- wb_dat_i  in  32  write data from the master.
- wb_dat_o  out  32  read data; valid only in the cycle wb_ack_o=1.
- wb_ack_o  out  1  normal termination; one-cycle pulse.
- wb_err_o  out  1  error termination; one-cycle pulse.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - outputs: wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
  - registers 1..NUM_REGS-1 = 0; FSM=IDLE; wait counter=0.
  - Reset asserted mid-access aborts the access with no ack and no register write.
- FSM states IDLE, WAIT, RESP; all outputs are registered.
  - IDLE: on an edge with cyc&stb=1 and WAIT_CYCLES=0, go to RESP. With WAIT_CYCLES>0, go to WAIT with counter=WAIT_CYCLES-1.
  - WAIT: counter decrements each edge; when counter=0, go to RESP.
  - RESP: the response pulse is high in this state; next edge always returns to IDLE.
- A request is sampled only in IDLE. A strobe still high in the cycle after RESP is treated as a new access, so back-to-back accesses are one access per (WAIT_CYCLES+2) cycles.
- Latency: the response is asserted exactly WAIT_CYCLES+1 cycles after the edge at which the request is sampled in IDLE.
- Decode and commit happen on the edge entering RESP, using the inputs present at that edge; the master holds its inputs stable until ack.
- Index valid (index < NUM_REGS):
  - wb_ack_o=1 in RESP.
  - Read: wb_dat_o = register[index]; register 0 reads ID_VALUE.
  - Write: each byte with sel=1 is updated. Writes to index 0 are silently dropped but still acked.
  - sel=4'b0000 on a write: acked, no change.
- Index invalid (index >= NUM_REGS):
  - wb_err_o=1 and wb_ack_o=0 in RESP.
  - No register change; wb_dat_o=0.
- wb_ack_o and wb_err_o are never both 1. Outside RESP, both are 0 and wb_dat_o=0.
- Abort: if wb_cyc_i or wb_stb_i is 0 at any edge while in WAIT, or at the transition edge into RESP, the FSM returns to IDLE. No write, no response pulse.
- A write followed by a read of the same index returns the new value; there is no read-during-write hazard because accesses are serialized.
- The counter is only as wide as needed for WAIT_CYCLES; no wrap is possible.

Test Plan:
- Reset, then read adr=0x0 -> ack after 1 cycle, dat_o=0x5E1E0001. Then read adr=0x4 -> dat_o=0x0.
- Write adr=0x8 dat=0xDEADBEEF sel=4'b1111, then read adr=0x8 -> 0xDEADBEEF. Then write dat=0x00000011 sel=4'b0001 and read -> 0xDEADBE11.
- Write 0x12345678 to adr=0x0 -> ack=1; read adr=0x0 -> still 0x5E1E0001.
- Read adr=0x20 (index 8, NUM_REGS=8) -> err=1, ack=0, dat_o=0. A write to adr=0x20 -> err=1, and registers 0..7 are unchanged.
- WAIT_CYCLES=3: ack asserted exactly 4 cycles after request sampling. Dropping stb after 2 cycles -> no ack, no write, and the next access completes normally.
- Assert rst_n=0 during WAIT of a write to adr=0x4 -> outputs 0 immediately. After release, read adr=0x4 -> 0x0.
